// File: rtl/pc_stack_if.sv
// ---------------------------------------------------------------------------
// pc_stack_if
// Control and status bundle for the program-counter / return-stack block.
//   master : drives en, op, D, clr_err; observes Q, depth, full, empty, ovf, unf
//   slave  : the pc_stack side of the same signals
// Parameters must match the pc_stack instance they are connected to.
// ---------------------------------------------------------------------------
interface pc_stack_if #(
  parameter int SIZE  = 16,
  parameter int DEPTH = 4
);
  localparam int DW = $clog2(DEPTH + 1);

  logic            en;       // advance enable
  logic [2:0]      op;       // 0 INC, 1 LOAD, 2 BRANCH, 3 CALL, 4 RET, 5-7 HOLD
  logic [SIZE-1:0] D;        // absolute target or signed branch offset
  logic            clr_err;  // clears sticky ovf/unf
  logic [SIZE-1:0] Q;        // current program counter
  logic [DW-1:0]   depth;    // valid return-stack entries
  logic            full;
  logic            empty;
  logic            ovf;      // sticky: CALL while full
  logic            unf;      // sticky: RET while empty

  modport master (
    output en, op, D, clr_err,
    input  Q, depth, full, empty, ovf, unf
  );

  modport slave (
    input  en, op, D, clr_err,
    output Q, depth, full, empty, ovf, unf
  );
endinterface

// File: rtl/pc_stack.sv
// ---------------------------------------------------------------------------
// pc_stack
// Program counter with a circular return-address stack.
//   clk      : rising-edge clock
//   rst      : asynchronous active-low reset
//   bus      : pc_stack_if.slave -- en/op/D/clr_err in, Q/depth/full/empty/
//              ovf/unf out
// Operations: INC (Q+STEP), LOAD (D), BRANCH (Q+signed D), CALL (push Q+STEP,
// jump to D), RET (pop into Q).  A CALL on a full stack overwrites the oldest
// entry and sets ovf; a RET on an empty stack acts as INC and sets unf.
// ---------------------------------------------------------------------------
module pc_stack #(
  parameter int              SIZE    = 16,
  parameter logic [SIZE-1:0] STEP    = 1,
  parameter int              DEPTH   = 4,
  parameter logic [SIZE-1:0] RST_VAL = '0
) (
  input  logic       clk,
  input  logic       rst,
  pc_stack_if.slave  bus
);

  localparam int DW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [DW-1:0] DEPTH_MAX = DW'(DEPTH);
  localparam logic [PW-1:0] PTR_MAX   = PW'(DEPTH - 1);

  typedef enum logic [2:0] {
    OP_INC    = 3'd0,
    OP_LOAD   = 3'd1,
    OP_BRANCH = 3'd2,
    OP_CALL   = 3'd3,
    OP_RET    = 3'd4
  } op_e;

  logic [SIZE-1:0] pc_q,    pc_d;
  logic [DW-1:0]   depth_q, depth_d;
  logic [PW-1:0]   ptr_q,   ptr_d;   // next slot to write; top entry is ptr_q-1
  logic            ovf_q,   ovf_d;
  logic            unf_q,   unf_d;
  logic [SIZE-1:0] stack_q [DEPTH];

  logic [SIZE-1:0] pc_inc;
  logic [PW-1:0]   ptr_inc;
  logic [PW-1:0]   ptr_dec;
  logic            is_full;
  logic            is_empty;
  logic            push;
  logic            ovf_set;
  logic            unf_set;

  assign pc_inc   = pc_q + STEP;
  assign ptr_inc  = (ptr_q == PTR_MAX) ? '0 : ptr_q + 1'b1;
  assign ptr_dec  = (ptr_q == '0) ? PTR_MAX : ptr_q - 1'b1;
  assign is_full  = (depth_q == DEPTH_MAX);
  assign is_empty = (depth_q == '0);

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    pc_d    = pc_q;
    depth_d = depth_q;
    ptr_d   = ptr_q;
    push    = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;

    if (bus.en) begin
      case (op_e'(bus.op))
        OP_INC:    pc_d = pc_inc;
        OP_LOAD:   pc_d = bus.D;
        // Two's-complement add: a SIZE-bit wrap gives signed offset behaviour.
        OP_BRANCH: pc_d = pc_q + bus.D;
        OP_CALL: begin
          pc_d  = bus.D;
          push  = 1'b1;
          ptr_d = ptr_inc;
          // When full, ptr_q already points at the oldest entry, so the push
          // overwrites it and depth stays saturated.
          if (is_full) ovf_set = 1'b1;
          else         depth_d = depth_q + 1'b1;
        end
        OP_RET: begin
          if (is_empty) begin
            pc_d    = pc_inc;
            unf_set = 1'b1;
          end else begin
            pc_d    = stack_q[ptr_dec];
            ptr_d   = ptr_dec;
            depth_d = depth_q - 1'b1;
          end
        end
        default: ;  // 5-7 hold
      endcase
    end

    // Clear is independent of en; a same-cycle new event wins over the clear.
    ovf_d = ovf_set | (ovf_q & ~bus.clr_err);
    unf_d = unf_set | (unf_q & ~bus.clr_err);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q    <= RST_VAL;
      depth_q <= '0;
      ptr_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      depth_q <= depth_d;
      ptr_q   <= ptr_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // NOTE: the stack array is deliberately left out of reset; depth=0 makes
  // every entry invalid, so its contents are never observable after reset.
  always_ff @(posedge clk) begin
    if (push) stack_q[ptr_q] <= pc_inc;
  end

  assign bus.Q     = pc_q;
  assign bus.depth = depth_q;
  assign bus.full  = is_full;
  assign bus.empty = is_empty;
  assign bus.ovf   = ovf_q;
  assign bus.unf   = unf_q;

endmodule

// File: tb/tb_pc_stack.sv
// ---------------------------------------------------------------------------
// tb_pc_stack
// Directed bench for pc_stack (SIZE=16, STEP=1, DEPTH=4, RST_VAL=0).  A small
// reference model (queue-based stack) predicts each cycle's outputs; the
// prediction is queued when stimulus is driven and popped after the edge.
// ---------------------------------------------------------------------------
module tb_pc_stack;

  localparam int SIZE  = 16;
  localparam int DEPTH = 4;
  localparam int DW    = $clog2(DEPTH + 1);

  localparam logic [2:0] INC = 3'd0, LOAD = 3'd1, BRANCH = 3'd2,
                         CALL = 3'd3, RET = 3'd4, HOLD = 3'd6;

  typedef struct {
    logic [SIZE-1:0] q;
    logic [DW-1:0]   depth;
    logic            full;
    logic            empty;
    logic            ovf;
    logic            unf;
  } exp_t;

  logic clk;
  logic rst;

  pc_stack_if #(.SIZE(SIZE), .DEPTH(DEPTH)) bus ();

  pc_stack #(
    .SIZE(SIZE), .STEP(16'd1), .DEPTH(DEPTH), .RST_VAL(16'h0000)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [SIZE-1:0] m_pc;
  logic [SIZE-1:0] m_stk[$];
  logic            m_ovf;
  logic            m_unf;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic model_reset();
    m_pc  = 16'h0000;
    m_stk.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic push_exp();
    exp_t e;
    e.q     = m_pc;
    e.depth = DW'(m_stk.size());
    e.full  = (m_stk.size() == DEPTH);
    e.empty = (m_stk.size() == 0);
    e.ovf   = m_ovf;
    e.unf   = m_unf;
    exp_q.push_back(e);
  endtask

  task automatic check_vec(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $error("FAIL %s: scoreboard empty, got Q=%h expected an entry", tag, bus.Q);
      return;
    end
    e = exp_q.pop_front();
    n_vec++;
    assert (bus.Q === e.q) else begin
      n_err++; $error("FAIL %s Q: got %h expected %h", tag, bus.Q, e.q);
    end
    n_vec++;
    assert (bus.depth === e.depth) else begin
      n_err++; $error("FAIL %s depth: got %0d expected %0d", tag, bus.depth, e.depth);
    end
    n_vec++;
    assert (bus.full === e.full) else begin
      n_err++; $error("FAIL %s full: got %b expected %b", tag, bus.full, e.full);
    end
    n_vec++;
    assert (bus.empty === e.empty) else begin
      n_err++; $error("FAIL %s empty: got %b expected %b", tag, bus.empty, e.empty);
    end
    n_vec++;
    assert (bus.ovf === e.ovf) else begin
      n_err++; $error("FAIL %s ovf: got %b expected %b", tag, bus.ovf, e.ovf);
    end
    n_vec++;
    assert (bus.unf === e.unf) else begin
      n_err++; $error("FAIL %s unf: got %b expected %b", tag, bus.unf, e.unf);
    end
  endtask

  // Drive one cycle of stimulus, predict, clock, then check #1 after the edge.
  task automatic step(input logic e, input logic [2:0] o, input logic [SIZE-1:0] d,
                      input logic c, input string tag);
    logic ovf_set, unf_set;
    bus.en = e; bus.op = o; bus.D = d; bus.clr_err = c;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (e) begin
      case (o)
        INC:    m_pc = m_pc + 16'd1;
        LOAD:   m_pc = d;
        BRANCH: m_pc = m_pc + d;
        CALL: begin
          if (m_stk.size() == DEPTH) begin
            void'(m_stk.pop_front());
            ovf_set = 1'b1;
          end
          m_stk.push_back(m_pc + 16'd1);
          m_pc = d;
        end
        RET: begin
          if (m_stk.size() == 0) begin
            m_pc    = m_pc + 16'd1;
            unf_set = 1'b1;
          end else begin
            m_pc = m_stk.pop_back();
          end
        end
        default: ;
      endcase
    end
    m_ovf = ovf_set | (m_ovf & ~c);
    m_unf = unf_set | (m_unf & ~c);
    push_exp();
    @(posedge clk);
    #1;
    check_vec(tag);
  endtask

  initial begin
    bus.en = 1'b0; bus.op = INC; bus.D = '0; bus.clr_err = 1'b0;
    rst = 1'b0;
    model_reset();
    #3;
    push_exp();
    check_vec("reset");
    @(negedge clk);
    rst = 1'b1;

    // Sequential increment and wrap
    step(1, INC, 16'h0000, 0, "inc1");
    step(1, INC, 16'h0000, 0, "inc2");
    step(1, INC, 16'h0000, 0, "inc3");
    step(1, LOAD, 16'hFFFF, 0, "load_ffff");
    step(1, INC, 16'h0000, 0, "inc_wrap");

    // Signed branch
    step(1, LOAD,   16'h0010, 0, "load_10");
    step(1, BRANCH, 16'hFFF0, 0, "br_neg16");
    step(1, LOAD,   16'h0010, 0, "load_10b");
    step(1, BRANCH, 16'h0005, 0, "br_pos5");

    // Nested call/return
    step(1, LOAD, 16'h0100, 0, "load_100");
    step(1, CALL, 16'h0200, 0, "call_200");
    step(1, CALL, 16'h0300, 0, "call_300");
    step(1, RET,  16'h0000, 0, "ret_201");
    step(1, RET,  16'h0000, 0, "ret_101");

    // Overflow: five calls into a four-deep stack, then unwind past empty
    step(1, LOAD, 16'h0A00, 0, "load_a00");
    for (int i = 1; i <= 5; i++) step(1, CALL, 16'(i * 16'h1000), 0, "ovf_call");
    for (int i = 0; i < 4; i++)  step(1, RET, 16'h0000, 0, "ovf_ret");
    step(1, RET, 16'h0000, 0, "unf_ret");

    // Hold behaviour with both sticky flags set
    step(0, CALL, 16'hBEEF, 0, "hold_en0");
    step(1, HOLD, 16'hBEEF, 0, "hold_op6");
    step(1, 3'd7, 16'hBEEF, 0, "hold_op7");

    // Flag clear: independent of en, and a same-cycle underflow wins
    step(0, INC, 16'h0000, 1, "clr_en0");
    step(1, RET, 16'h0000, 1, "clr_with_unf");
    step(1, HOLD, 16'h0000, 1, "clr_alone");

    // Asynchronous reset between edges with depth=3
    step(1, LOAD, 16'h4000, 0, "load_4000");
    for (int i = 0; i < 3; i++) step(1, CALL, 16'(16'h5000 + i * 16'h100), 0, "pre_rst_call");
    #2;
    rst = 1'b0;
    model_reset();
    push_exp();
    #1;
    check_vec("async_rst");
    @(negedge clk);
    rst = 1'b1;
    step(1, RET, 16'h0000, 0, "ret_after_rst");
    step(1, CALL, 16'h0777, 0, "call_after_rst");
    step(1, RET, 16'h0000, 0, "ret_after_call");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
